// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte-level helpers for the iterative encryption engine.
package aes_pkg;

  typedef logic [15:0][7:0] state_t;

  localparam int unsigned NR_AES128 = 10;
  localparam logic [7:0]  RCON_INIT = 8'h01;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  // Index 0 is the leftmost literal, so SBOX[x] reads the table row-major.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One forward AES round plus the matching on-the-fly key expansion step; purely combinational.
module aes_enc_round
  import aes_pkg::*;
(
  input  state_t     i_st,
  input  state_t     i_rk,
  input  logic [7:0] i_rcon,
  input  logic       i_last,
  output state_t     o_st,
  output state_t     o_rk
);

  state_t      w_sb, w_sr, w_mc;
  logic [127:0] w_k;
  logic [31:0] w_rot, w_temp, w_n0, w_n1, w_n2, w_n3;

  always_comb begin
    for (int b = 0; b < 16; b++) w_sb[b] = sbox(i_st[b]);
  end

  // FIPS byte (row r, col c) lives at array index 15-(4c+r).
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sr[15-(4*c+r)] = w_sb[15-(4*((c+r)%4)+r)];
      end
    end
  end

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = w_sr[15-4*c];
      a1 = w_sr[14-4*c];
      a2 = w_sr[13-4*c];
      a3 = w_sr[12-4*c];
      w_mc[15-4*c] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      w_mc[14-4*c] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      w_mc[13-4*c] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      w_mc[12-4*c] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

  assign w_k    = i_rk;
  assign w_rot  = {w_k[23:0], w_k[31:24]};
  assign w_temp = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])}
                  ^ {i_rcon, 24'h000000};
  assign w_n0   = w_k[127:96] ^ w_temp;
  assign w_n1   = w_k[95:64] ^ w_n0;
  assign w_n2   = w_k[63:32] ^ w_n1;
  assign w_n3   = w_k[31:0] ^ w_n2;
  assign o_rk   = {w_n0, w_n1, w_n2, w_n3};

  assign o_st = (i_last ? w_sr : w_mc) ^ o_rk;

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
// Also returns the round-10 key so a decryptor can start its reverse key schedule from it.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int unsigned NR = NR_AES128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0][7:0] data,
  input  logic [15:0][7:0] key,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0][7:0] c_out,
  output logic [15:0][7:0] last_key,
  output logic [3:0]      rc
);

  if (NR != NR_AES128) begin : g_nr_check
    $error("aes_encrypt_iter: only NR=10 (AES-128) is supported");
  end

  localparam logic [3:0] RND_LAST = 4'(NR);

  fsm_e       r_state, w_state_nxt;
  state_t     r_st, w_st_nxt, r_rk, w_rk_nxt, r_c_out, w_c_out_nxt, r_last_key, w_last_key_nxt;
  logic [7:0] r_rcon, w_rcon_nxt;
  logic [3:0] r_rnd, w_rnd_nxt;
  state_t     w_rnd_st, w_rnd_rk;
  logic       w_last;

  assign w_last = (r_rnd == RND_LAST);

  aes_enc_round u_round (
    .i_st   (r_st),
    .i_rk   (r_rk),
    .i_rcon (r_rcon),
    .i_last (w_last),
    .o_st   (w_rnd_st),
    .o_rk   (w_rnd_rk)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_st       <= '0;
      r_rk       <= '0;
      r_rcon     <= '0;
      r_rnd      <= '0;
      r_c_out    <= '0;
      r_last_key <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_st       <= w_st_nxt;
      r_rk       <= w_rk_nxt;
      r_rcon     <= w_rcon_nxt;
      r_rnd      <= w_rnd_nxt;
      r_c_out    <= w_c_out_nxt;
      r_last_key <= w_last_key_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_st_nxt       = r_st;
    w_rk_nxt       = r_rk;
    w_rcon_nxt     = r_rcon;
    w_rnd_nxt      = r_rnd;
    w_c_out_nxt    = r_c_out;
    w_last_key_nxt = r_last_key;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_st_nxt    = data ^ key;
          w_rk_nxt    = key;
          w_rcon_nxt  = RCON_INIT;
          w_rnd_nxt   = 4'd1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_st_nxt   = w_rnd_st;
        w_rk_nxt   = w_rnd_rk;
        w_rcon_nxt = xtime(r_rcon);
        w_rnd_nxt  = w_last ? r_rnd : r_rnd + 4'd1;
        if (w_last) begin
          w_c_out_nxt    = w_rnd_st;
          w_last_key_nxt = w_rnd_rk;
          w_state_nxt    = DONE;
        end
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign c_out     = r_c_out;
  assign last_key  = r_last_key;
  assign rc        = (r_state == RUN) ? r_rnd : 4'd0;

endmodule
